// File: rtl/periph_obi_arbiter.sv
// periph_obi_arbiter
//   Round-robin arbiter that shares one OBI slave port among NHARTS OBI
//   masters. One transaction is in flight at a time. A master that wins
//   without an immediate slave grant stays locked as the owner until it is
//   granted.
//
// Ports
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   master_req_i     per-hart OBI request  (req, we, be, addr, wdata)
//   master_resp_o    per-hart OBI response (gnt, rvalid, rdata)
//   slave_req_o      forwarded request to the peripheral slave
//   slave_resp_i     response from the peripheral slave
//   busy_o           locked, or a response is outstanding
//   owner_o          current or last owner index (debug)

package periph_obi_pkg;
    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;
endpackage

module periph_obi_arbiter
    import periph_obi_pkg::*;
#(
    parameter int NHARTS = 3,
    parameter int IDX_W  = $clog2(NHARTS)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  obi_req_t  [NHARTS-1:0]  master_req_i,
    output obi_resp_t [NHARTS-1:0]  master_resp_o,
    output obi_req_t                slave_req_o,
    input  obi_resp_t               slave_resp_i,
    output logic                    busy_o,
    output logic      [IDX_W-1:0]   owner_o
);

    typedef enum logic {IDLE, WAIT_R} state_t;

    state_t             state;
    logic               locked;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   owner;

    logic [IDX_W-1:0]   win;
    logic               any_req;
    logic [IDX_W-1:0]   sel;
    logic [IDX_W-1:0]   sel_next;
    logic               fwd;
    logic               acc;
    logic               rsp_vld;

    // Round-robin search starting at rr_ptr. Walking the offsets from the
    // farthest down to zero lets the closest requester overwrite the others.
    always_comb begin
        win     = '0;
        any_req = 1'b0;
        for (int i = NHARTS - 1; i >= 0; i--) begin
            if (master_req_i[(int'(rr_ptr) + i) % NHARTS].req) begin
                win     = IDX_W'((int'(rr_ptr) + i) % NHARTS);
                any_req = 1'b1;
            end
        end
    end

    // A locked owner is forwarded even with req low, so a misbehaving
    // owner simply presents req=0 and cannot be granted.
    assign sel      = locked ? owner : win;
    assign sel_next = (sel == IDX_W'(NHARTS - 1)) ? '0 : sel + 1'b1;

    // Outputs are gated by rst_ni so the reset values appear immediately
    // while reset is held, not only after the next edge.
    assign fwd     = rst_ni && (state == IDLE) && (locked || any_req);
    assign rsp_vld = rst_ni && (state == WAIT_R) && slave_resp_i.rvalid;

    always_comb begin
        slave_req_o = '0;
        if (fwd)
            slave_req_o = master_req_i[sel];
    end

    // A slave gnt with no forwarded request is ignored.
    assign acc = slave_req_o.req && slave_resp_i.gnt;

    always_comb begin
        master_resp_o = '0;
        for (int m = 0; m < NHARTS; m++) begin
            master_resp_o[m].gnt = acc && (sel == IDX_W'(m));
            if (rsp_vld && (owner == IDX_W'(m))) begin
                master_resp_o[m].rvalid = 1'b1;
                master_resp_o[m].rdata  = slave_resp_i.rdata;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state  <= IDLE;
            locked <= 1'b0;
            rr_ptr <= '0;
            owner  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (acc) begin
                        owner  <= sel;
                        rr_ptr <= sel_next;
                        locked <= 1'b0;
                        state  <= WAIT_R;
                    end else if (!locked && any_req) begin
                        locked <= 1'b1;
                        owner  <= win;
                    end
                end
                WAIT_R: begin
                    // No arbitration in the rvalid cycle; next one starts in IDLE.
                    if (slave_resp_i.rvalid)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy_o  = locked | (state == WAIT_R);
    assign owner_o = owner;

endmodule
